reg_wr_enable_ctrl: RTL and testbench
=====================================

// Module: reg_wr_enable_ctrl
// PURPOSE
//   Registered, multi-port register-file write-enable generator. Arbitrates NUM_WR write
//   requests per cycle and decodes each winner's address to a one-hot enable. Outputs one
//   cycle later, aligned with write-back data. Sits between the write-back stage and the
//   register file. Flags out-of-range addresses and counts same-address port conflicts.
// PARAMETERS
//   NUM_REGS  8  registers in file; 2..2**ADDR_W
//   ADDR_W    3  register address width
//   NUM_WR    2  write ports; 1..4; port 0 = highest priority
// PORTS
//   clk           in   1               rising-edge clock
//   rst           in   1               synchronous, active-high reset
//   wr_valid      in   NUM_WR          per-port write request
//   wr_addr       in   NUM_WR*ADDR_W   port p address at [p*ADDR_W +: ADDR_W]
//   hold          in   1               pipeline stall; freezes outputs, grants nothing
//   wr_grant      out  NUM_WR          comb.; request consumed this cycle
//   enable_mask   out  NUM_REGS        registered one-hot-per-port OR of granted writes
//   port_sel      out  NUM_REGS*NUM_WR reg r driven by port p at [r*NUM_WR+p]; <=1 bit/reg
//   en_valid      out  1               registered; enable_mask non-zero
//   addr_err      out  1               sticky; granted request had addr >= NUM_REGS
//   conflict_cnt  out  8               saturating count of cycles with a lost conflict
// BEHAVIOUR
//   - Reset (rst=1 at posedge): enable_mask=0, port_sel=0, en_valid=0, addr_err=0,
//     conflict_cnt=0. Reset has priority over hold. wr_grant stays combinational; it is
//     forced 0 while rst=1. Reset mid-stream drops all in-flight enables.
//   - Grant (comb.): wr_grant[p] = wr_valid[p] & ~hold & ~rst & no lower port q<p with
//     wr_valid[q] and wr_addr[q]==wr_addr[p].
//     Loser stays ungranted; the requester holds valid/addr and retries.
//   - Latency 1: grants in cycle t appear on enable_mask/port_sel at t+1, for exactly one
//     cycle. Next cycle with no grants gives enable_mask=0.
//   - hold=1: enable_mask, port_sel, en_valid, conflict_cnt keep their values;
//     wr_grant=0.
//   - Out-of-range: granted addr >= NUM_REGS is consumed (grant=1) with no enable bit.
//     addr_err sets at t+1 and stays set until rst. Same-address arbitration still applies.
//   - Conflict: any cycle (~hold) where >=1 valid port loses gives conflict_cnt+1 at t+1.
//     Saturates at 255; never wraps.
//   - Distinct in-range addresses on all ports: all granted in the same cycle; several
//     enable bits are set at t+1.
//   - NUM_WR=1: no conflicts possible; conflict_cnt stays 0.
// CONFIGURATION
//   R0_ZERO_EN defined: register 0 is hard-wired zero. A granted write to addr 0 is
//     consumed and silently dropped. enable_mask[0] and port_sel[0*NUM_WR +: NUM_WR] are
//     constant 0. Addr 0 still takes part in conflict arbitration.
//   R0_ZERO_EN undefined: register 0 is ordinary.
// STRUCTURE
//   - Package regfile_pkg: REG_NUM_REGS, REG_ADDR_W, REG_NUM_WR defaults;
//     CNT_W=8, CNT_MAX=8'hFF.
//   - Sub-module addr_onehot #(ADDR_W, NUM_REGS): combinational addr+valid -> one-hot
//     plus in_range. One instance per port.
//   - Top: priority/conflict logic, output register stage, sticky error, counter.
// TESTING
//   1. Reset: rst=1 2 cycles with wr_valid=2'b11 -> wr_grant=0; all outputs 0 after
//      release.
//   2. Distinct ports: addr p0=3, p1=5, both valid -> grant=2'b11; next cycle
//      enable_mask=8'h28, port_sel bits [6] and [11] set, en_valid=1.
//   3. Conflict: p0 and p1 both addr 6 -> grant=2'b01, enable_mask=8'h40 at t+1,
//      conflict_cnt=1. p1 held -> grant=2'b10 next cycle.
//   4. Hold: grant addr 2, then hold=1 for 3 cycles -> enable_mask stays 8'h04 and
//      wr_grant=0 throughout. Release -> enable_mask=0.
//   5. Error/saturation: NUM_REGS=6, addr 7 -> grant=1, enable_mask=0, addr_err=1
//      (sticky). 300 conflict cycles -> conflict_cnt=255.
//   6. R0_ZERO_EN defined: write addr 0 -> grant=1, enable_mask=0, en_valid=0.
//      Undefined: enable_mask=8'h01.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the register-file write-enable generator.
package regfile_pkg;
  localparam int REG_NUM_REGS = 8;
  localparam int REG_ADDR_W   = 3;
  localparam int REG_NUM_WR   = 2;
  localparam int CNT_W        = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
endpackage

// File: rtl/reg_wr_enable_ctrl_addr_onehot.sv
// addr_onehot: combinational decode of one write port's address into a
// one-hot register enable, plus a flag telling whether the address names an
// existing register. No enable bit is produced for an out-of-range address.
module addr_onehot #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                valid,
  output logic [NUM_REGS-1:0] onehot,
  output logic                in_range
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));

  // One comparator per register; at most one can match a given address.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_dec
    assign onehot[r] = valid & (addr == ADDR_W'(r));
  end

endmodule

// File: rtl/reg_wr_enable_ctrl.sv
// reg_wr_enable_ctrl: multi-port register-file write-enable generator.
// Arbitrates same-address write requests (port 0 wins), decodes winners to
// one-hot enables and registers them so they line up with write-back data.
// Optional macro: R0_ZERO_EN makes register 0 a hard-wired zero (writes to
// address 0 are consumed but produce no enable).
//
// Handshake: wr_valid[p]/wr_grant[p] form a valid/ready pair. A request is
// consumed in the cycle both are high; a requester that is not granted must
// keep wr_valid[p] and its address stable and retry next cycle.
module reg_wr_enable_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_NUM_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_WR   = REG_NUM_WR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_valid,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic                       hold,
  output logic [NUM_WR-1:0]          wr_grant,
  output logic [NUM_REGS-1:0]        enable_mask,
  output logic [NUM_REGS*NUM_WR-1:0] port_sel,
  output logic                       en_valid,
  output logic                       addr_err,
  output logic [CNT_W-1:0]           conflict_cnt
);

  logic [NUM_WR-1:0]          blocked;
  logic [NUM_WR-1:0]          lost;
  logic [NUM_WR-1:0]          in_range;
  logic [NUM_REGS-1:0]        onehot [NUM_WR];
  logic [NUM_REGS-1:0]        mask_nxt;
  logic [NUM_REGS*NUM_WR-1:0] sel_nxt;
  logic                       err_nxt;

  // A port is blocked when a higher-priority (lower-index) valid port targets
  // the same address; out-of-range addresses arbitrate the same way.
  always_comb begin
    blocked = '0;
    for (int p = 1; p < NUM_WR; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_valid[q] &&
            (wr_addr[q*ADDR_W +: ADDR_W] == wr_addr[p*ADDR_W +: ADDR_W])) begin
          blocked[p] = 1'b1;
        end
      end
    end
  end

  assign wr_grant = wr_valid & ~blocked & {NUM_WR{~hold & ~rst}};
  assign lost     = wr_valid & blocked;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_port
    addr_onehot #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_dec (
      .addr     (wr_addr[p*ADDR_W +: ADDR_W]),
      .valid    (wr_grant[p]),
      .onehot   (onehot[p]),
      .in_range (in_range[p])
    );
  end

  // Merge the granted ports' decodes into the next enable mask / port map.
  always_comb begin
    mask_nxt = '0;
    sel_nxt  = '0;
    err_nxt  = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (onehot[p][r]) begin
          mask_nxt[r]            = 1'b1;
          sel_nxt[r*NUM_WR + p]  = 1'b1;
        end
      end
      if (wr_grant[p] && !in_range[p]) begin
        err_nxt = 1'b1;
      end
    end
`ifdef R0_ZERO_EN
    mask_nxt[0]          = 1'b0;
    sel_nxt[NUM_WR-1:0]  = '0;
`else
`endif
  end

  // Output stage: reset wins, hold freezes, otherwise capture this cycle's grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_mask  <= '0;
      port_sel     <= '0;
      en_valid     <= 1'b0;
      addr_err     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      addr_err <= addr_err | err_nxt;
      if (!hold) begin
        enable_mask <= mask_nxt;
        port_sel    <= sel_nxt;
        en_valid    <= |mask_nxt;
        if ((|lost) && (conflict_cnt != CNT_MAX)) begin
          conflict_cnt <= conflict_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wr_enable_ctrl.sv
// Directed bench for reg_wr_enable_ctrl: a default 8-register instance plus a
// 6-register instance for out-of-range addressing. Both share the stimulus.
module tb_reg_wr_enable_ctrl;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [1:0]  wr_valid;
  logic [5:0]  wr_addr;

  logic [1:0]  wr_grant;
  logic [7:0]  enable_mask;
  logic [15:0] port_sel;
  logic        en_valid;
  logic        addr_err;
  logic [7:0]  conflict_cnt;

  logic [1:0]  wr_grant6;
  logic [5:0]  enable_mask6;
  logic [11:0] port_sel6;
  logic        en_valid6;
  logic        addr_err6;
  logic [7:0]  conflict_cnt6;

  int errors = 0;
  int checks = 0;

  reg_wr_enable_ctrl #(.NUM_REGS(8), .ADDR_W(3), .NUM_WR(2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .hold(hold),
    .wr_grant(wr_grant), .enable_mask(enable_mask), .port_sel(port_sel),
    .en_valid(en_valid), .addr_err(addr_err), .conflict_cnt(conflict_cnt)
  );

  reg_wr_enable_ctrl #(.NUM_REGS(6), .ADDR_W(3), .NUM_WR(2)) dut6 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .hold(hold),
    .wr_grant(wr_grant6), .enable_mask(enable_mask6), .port_sel(port_sel6),
    .en_valid(en_valid6), .addr_err(addr_err6), .conflict_cnt(conflict_cnt6)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; hold = 1'b0; wr_valid = 2'b00; wr_addr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; hold = 1'b0; wr_valid = 2'b11; wr_addr = {3'd1, 3'd2};
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (wr_grant !== 2'b00) begin
        errors++; $display("FAIL reset_grant: got %b want 00", wr_grant);
      end
      tick();
    end
    rst = 1'b0; wr_valid = 2'b00;
    tick();
    checks++;
    if (enable_mask !== 8'h00 || port_sel !== 16'h0000 || en_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outs: mask=%h sel=%h ev=%b want 00/0000/0",
                         enable_mask, port_sel, en_valid);
    end
    checks++;
    if (addr_err !== 1'b0 || conflict_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_err_cnt: err=%b cnt=%0d want 0/0", addr_err, conflict_cnt);
    end
  endtask

  task automatic test_distinct;
    wr_valid = 2'b11; wr_addr = {3'd5, 3'd3};
    #1;
    checks++;
    if (wr_grant !== 2'b11) begin
      errors++; $display("FAIL distinct_grant: got %b want 11", wr_grant);
    end
    tick();
    wr_valid = 2'b00;
    checks++;
    if (enable_mask !== 8'h28 || port_sel !== 16'h0840 || en_valid !== 1'b1) begin
      errors++; $display("FAIL distinct_outs: mask=%h sel=%h ev=%b want 28/0840/1",
                         enable_mask, port_sel, en_valid);
    end
    tick();
    checks++;
    if (enable_mask !== 8'h00 || port_sel !== 16'h0000 || en_valid !== 1'b0) begin
      errors++; $display("FAIL distinct_clear: mask=%h sel=%h ev=%b want 00/0000/0",
                         enable_mask, port_sel, en_valid);
    end
  endtask

  task automatic test_conflict;
    wr_valid = 2'b11; wr_addr = {3'd6, 3'd6};
    #1;
    checks++;
    if (wr_grant !== 2'b01) begin
      errors++; $display("FAIL conflict_grant: got %b want 01", wr_grant);
    end
    tick();
    wr_valid = 2'b10;
    checks++;
    if (enable_mask !== 8'h40 || port_sel !== 16'h1000 || conflict_cnt !== 8'd1) begin
      errors++; $display("FAIL conflict_win: mask=%h sel=%h cnt=%0d want 40/1000/1",
                         enable_mask, port_sel, conflict_cnt);
    end
    #1;
    checks++;
    if (wr_grant !== 2'b10) begin
      errors++; $display("FAIL conflict_retry_grant: got %b want 10", wr_grant);
    end
    tick();
    wr_valid = 2'b00;
    checks++;
    if (enable_mask !== 8'h40 || port_sel !== 16'h2000 || conflict_cnt !== 8'd1) begin
      errors++; $display("FAIL conflict_retry: mask=%h sel=%h cnt=%0d want 40/2000/1",
                         enable_mask, port_sel, conflict_cnt);
    end
    tick();
  endtask

  task automatic test_invalid_no_block;
    // An idle higher-priority port with the same address must not block.
    wr_valid = 2'b10; wr_addr = {3'd3, 3'd3};
    #1;
    checks++;
    if (wr_grant !== 2'b10) begin
      errors++; $display("FAIL idle_no_block: got %b want 10", wr_grant);
    end
    tick();
    wr_valid = 2'b00;
    checks++;
    if (enable_mask !== 8'h08 || port_sel !== 16'h0080 || conflict_cnt !== 8'd1) begin
      errors++; $display("FAIL idle_no_block_outs: mask=%h sel=%h cnt=%0d want 08/0080/1",
                         enable_mask, port_sel, conflict_cnt);
    end
    tick();
  endtask

  task automatic test_hold;
    wr_valid = 2'b01; wr_addr = {3'd0, 3'd2};
    tick();
    hold = 1'b1; wr_valid = 2'b11; wr_addr = {3'd2, 3'd2};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wr_grant !== 2'b00) begin
        errors++; $display("FAIL hold_grant: cycle %0d got %b want 00", i, wr_grant);
      end
      tick();
      checks++;
      if (enable_mask !== 8'h04 || en_valid !== 1'b1 || conflict_cnt !== 8'd1) begin
        errors++; $display("FAIL hold_freeze: cycle %0d mask=%h ev=%b cnt=%0d want 04/1/1",
                           i, enable_mask, en_valid, conflict_cnt);
      end
    end
    hold = 1'b0; wr_valid = 2'b00;
    tick();
    checks++;
    if (enable_mask !== 8'h00 || en_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: mask=%h ev=%b want 00/0", enable_mask, en_valid);
    end
  endtask

  task automatic test_reset_mid;
    wr_valid = 2'b11; wr_addr = {3'd1, 3'd4};
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (wr_grant !== 2'b00) begin
      errors++; $display("FAIL midreset_grant: got %b want 00", wr_grant);
    end
    tick();
    rst = 1'b0; wr_valid = 2'b00;
    checks++;
    if (enable_mask !== 8'h00 || port_sel !== 16'h0000 || conflict_cnt !== 8'd0) begin
      errors++; $display("FAIL midreset_drop: mask=%h sel=%h cnt=%0d want 00/0000/0",
                         enable_mask, port_sel, conflict_cnt);
    end
  endtask

  task automatic test_addr_err;
    do_reset();
    wr_valid = 2'b01; wr_addr = {3'd0, 3'd7};
    #1;
    checks++;
    if (wr_grant6 !== 2'b01) begin
      errors++; $display("FAIL err_grant: got %b want 01", wr_grant6);
    end
    tick();
    wr_valid = 2'b00;
    checks++;
    if (enable_mask6 !== 6'h00 || en_valid6 !== 1'b0 || addr_err6 !== 1'b1) begin
      errors++; $display("FAIL err_set: mask=%h ev=%b err=%b want 00/0/1",
                         enable_mask6, en_valid6, addr_err6);
    end
    checks++;
    if (enable_mask !== 8'h80 || addr_err !== 1'b0) begin
      errors++; $display("FAIL err_inrange8: mask=%h err=%b want 80/0", enable_mask, addr_err);
    end
    repeat (3) tick();
    checks++;
    if (addr_err6 !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", addr_err6);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    wr_valid = 2'b11; wr_addr = {3'd1, 3'd1};
    repeat (10) tick();
    checks++;
    if (conflict_cnt !== 8'd10) begin
      errors++; $display("FAIL sat_mid: got %0d want 10", conflict_cnt);
    end
    repeat (290) tick();
    checks++;
    if (conflict_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_top: got %0d want 255", conflict_cnt);
    end
    repeat (5) tick();
    checks++;
    if (conflict_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_nowrap: got %0d want 255", conflict_cnt);
    end
    wr_valid = 2'b00;
    tick();
  endtask

  task automatic test_r0;
    logic [7:0]  exp_mask;
    logic [15:0] exp_sel;
    logic        exp_ev;
`ifdef R0_ZERO_EN
    exp_mask = 8'h00; exp_sel = 16'h0000; exp_ev = 1'b0;
`else
    exp_mask = 8'h01; exp_sel = 16'h0001; exp_ev = 1'b1;
`endif
    do_reset();
    wr_valid = 2'b01; wr_addr = {3'd0, 3'd0};
    #1;
    checks++;
    if (wr_grant !== 2'b01) begin
      errors++; $display("FAIL r0_grant: got %b want 01", wr_grant);
    end
    tick();
    checks++;
    if (enable_mask !== exp_mask || port_sel !== exp_sel || en_valid !== exp_ev) begin
      errors++; $display("FAIL r0_outs: mask=%h sel=%h ev=%b want %h/%h/%b",
                         enable_mask, port_sel, en_valid, exp_mask, exp_sel, exp_ev);
    end
    wr_valid = 2'b11;
    #1;
    checks++;
    if (wr_grant !== 2'b01) begin
      errors++; $display("FAIL r0_arb: got %b want 01", wr_grant);
    end
    tick();
    wr_valid = 2'b00;
    checks++;
    if (conflict_cnt !== 8'd1) begin
      errors++; $display("FAIL r0_conflict: got %0d want 1", conflict_cnt);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; wr_valid = 2'b00; wr_addr = '0;
    test_reset();
    test_distinct();
    test_conflict();
    test_invalid_no_block();
    test_hold();
    test_reset_mid();
    test_addr_err();
    test_saturation();
    test_r0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
